stopwatch_controller: RTL and testbench
=======================================

Name: stopwatch_controller

Overview:
Control FSM for the MM:SS stopwatch datapath (clock divider, cascaded BCD counters, 7-seg mux).
- Debounces three raw push-buttons: start/stop, lap and clear.
- Generates the count-enable tick that drives the BCD counter chain, and the synchronous clear pulse for it.
- Selects either the live time or a held lap time for the display path.
- Sits between board buttons and the counter/display logic, all in the clk_in domain.

Parameters:
CLK_HZ, 50000000, frequency of clk_in in Hz
TICK_HZ, 10, rate of tick_en pulses while counting
DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a button level (10 ms at 50 MHz)

Ports:
clk_in  input  1  system clock
rst  input  1  asynchronous reset, active-high
btn_start_stop  input  1  raw start/stop button, active-high, asynchronous to clk_in
btn_lap  input  1  raw lap button, active-high, asynchronous
btn_clear  input  1  raw clear button, active-high, asynchronous
time_bcd  input  16  live count from counter chain {min_tens, min_ones, sec_tens, sec_ones}
tick_en  output  1  one-cycle count-enable pulse to the counter chain
clear_out  output  1  one-cycle synchronous clear pulse to the counter chain
disp_bcd  output  16  value to display
lap_active  output  1  high while the display shows the held lap value
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP

Behaviour:
Reset (rst, asynchronous, active-high; clock clk_in):
- State IDLE; tick_en=0, clear_out=0, lap_active=0, lap_reg=0.
- Prescaler=0; debounced levels=0; synchronizers=0.

Button path (identical per button):
- 2-flop synchronizer, then a debounce counter.
- The counter restarts whenever the synced sample differs from the debounced level.
- The debounced level updates when the synced sample has been stable for DEBOUNCE_CYCLES consecutive cycles.
- A rising edge of the debounced level produces a one-cycle event (ev_ss, ev_lap, ev_clr).
- Event latency from a clean raw edge: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- Falling edges produce no event.
- Holding a button produces exactly one event.

Prescaler:
- DIV = CLK_HZ/TICK_HZ (integer, DIV >= 2); counts 0..DIV-1.
- Increments only in RUN or LAP.
- Held (not cleared) in PAUSE, so a paused partial tick is preserved.
- Cleared to 0 in IDLE and on any clear_out.
- tick_en is registered and high for exactly one cycle, the cycle after the prescaler equals DIV-1, in RUN/LAP only.

FSM (evaluated each cycle; simultaneous events are prioritised clear > start/stop > lap, and only the highest-priority event acts that cycle):
- IDLE:
  - ev_ss: go to RUN.
  - ev_clr: pulse clear_out, stay in IDLE.
  - ev_lap: ignored.
- RUN:
  - ev_ss: go to PAUSE.
  - ev_lap: lap_reg <= time_bcd, go to LAP.
  - ev_clr: ignored (counting is never cleared while running).
- LAP (counting continues, display frozen):
  - ev_lap: recapture lap_reg <= time_bcd, stay in LAP.
  - ev_clr: release the hold and go to RUN; no clear_out pulse.
  - ev_ss: go to PAUSE; the hold is released.
- PAUSE:
  - ev_ss: go to RUN; the prescaler resumes from its held value.
  - ev_clr: pulse clear_out, zero the prescaler, go to IDLE.
  - ev_lap: ignored.

Outputs:
- lap_active = (state==LAP), registered with the state.
- disp_bcd = lap_active ? lap_reg : time_bcd (combinational mux).
- clear_out is registered, one cycle wide, coincident with the state update.
- tick_en and clear_out are never high in the same cycle.
- The block does not inspect or modify BCD digit values; counter wrap is owned by the counter chain.
- rst asserted mid-count or mid-debounce returns everything to the reset values above within the same cycle. No tick_en is issued until a fresh ev_ss after rst deasserts.

Test Plan:
(Bench parameters: CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4, so DIV=10.)
- Press start for 20 cycles -> one ev_ss; state 00->01; tick_en pulses every 10 cycles; releasing the button produces no event.
- Bounce btn_start_stop 1/0 every 2 cycles for 12 cycles, then hold high -> exactly one transition, accepted only after 4 stable cycles.
- In RUN with time_bcd=16'h0123, press lap -> state 11, disp_bcd=16'h0123 while time_bcd advances; tick_en continues. Press lap again at time_bcd=16'h0130 -> disp_bcd=16'h0130. Press clear -> state 01, disp_bcd tracks time_bcd, clear_out stays 0.
- RUN, stop at prescaler=6 -> PAUSE, no tick_en. Restart -> first tick_en after 4 more cycles. Press clear while in PAUSE -> clear_out high for 1 cycle, state 00.
- Events ev_clr and ev_ss in the same cycle while in PAUSE -> clear wins: state 00, clear_out=1. Same pair in RUN -> start/stop wins (clear ignored in RUN): state 10.
- Assert rst during LAP with a tick pending -> state 00, lap_active=0, disp_bcd=time_bcd, tick_en=0 immediately; no ticks until the next start.

Source files
------------

// File: rtl/stopwatch_controller_if.sv
// Signal bundle between the stopwatch controller, the board buttons and the
// BCD counter / 7-segment display path.
interface stopwatch_controller_if;
   logic        btn_start_stop;
   logic        btn_lap;
   logic        btn_clear;
   logic [15:0] time_bcd;
   logic        tick_en;
   logic        clear_out;
   logic [15:0] disp_bcd;
   logic        lap_active;
   logic [1:0]  state;

   modport master (
      input  btn_start_stop,
      input  btn_lap,
      input  btn_clear,
      input  time_bcd,
      output tick_en,
      output clear_out,
      output disp_bcd,
      output lap_active,
      output state
   );

   modport slave (
      output btn_start_stop,
      output btn_lap,
      output btn_clear,
      output time_bcd,
      input  tick_en,
      input  clear_out,
      input  disp_bcd,
      input  lap_active,
      input  state
   );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: debounces the three buttons, generates the counter
// tick and clear pulses, and selects live or held lap time for the display.
module stopwatch_controller #(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 10,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic                    clk_in,
   input logic                    rst,
   stopwatch_controller_if.master bus
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
   localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_e;

   // Button bit order: [0] start/stop, [1] lap, [2] clear
   logic [2:0]    raw_s;
   logic [2:0]    sync1_r;
   logic [2:0]    sync2_r;
   logic [2:0]    db_level_r;
   logic [2:0]    db_prev_r;
   logic [CW-1:0] db_cnt_r [3];
   logic [2:0]    ev_s;
   logic          ev_ss_s;
   logic          ev_lap_s;
   logic          ev_clr_s;

   state_e        state_r;
   state_e        state_nxt_s;
   logic          clear_nxt_s;
   logic          capture_s;
   logic          counting_s;
   logic          clear_out_r;
   logic          lap_active_r;
   logic [15:0]   lap_reg_r;
   logic [PW-1:0] presc_r;
   logic          tick_en_r;

   assign raw_s = {bus.btn_clear, bus.btn_lap, bus.btn_start_stop};

   // Two-flop synchronizers for the asynchronous buttons
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            db_cnt_r[i] <= '0;
         end
         db_level_r <= 3'b000;
         db_prev_r  <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] == db_level_r[i]) begin
               db_cnt_r[i] <= '0;
            end else if (db_cnt_r[i] == DB_MAX) begin
               db_cnt_r[i]   <= '0;
               db_level_r[i] <= sync2_r[i];
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + CW'(1);
            end
         end
         db_prev_r <= db_level_r;
      end
   end

   assign ev_s       = db_level_r & ~db_prev_r;
   assign ev_ss_s    = ev_s[0];
   assign ev_lap_s   = ev_s[1];
   assign ev_clr_s   = ev_s[2];
   assign counting_s = (state_r == ST_RUN) || (state_r == ST_LAP);

   // Next-state logic; events a state ignores never block lower-priority ones
   always_comb begin
      state_nxt_s = state_r;
      clear_nxt_s = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ev_clr_s) begin
               clear_nxt_s = 1'b1;
            end else if (ev_ss_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (ev_ss_s) begin
               state_nxt_s = ST_PAUSE;
            end else if (ev_lap_s) begin
               capture_s   = 1'b1;
               state_nxt_s = ST_LAP;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_LAP: begin
            if (ev_clr_s) begin
               state_nxt_s = ST_RUN;
            end else if (ev_ss_s) begin
               state_nxt_s = ST_PAUSE;
            end else if (ev_lap_s) begin
               capture_s   = 1'b1;
               state_nxt_s = ST_LAP;
            end else begin
               state_nxt_s = ST_LAP;
            end
         end
         ST_PAUSE: begin
            if (ev_clr_s) begin
               clear_nxt_s = 1'b1;
               state_nxt_s = ST_IDLE;
            end else if (ev_ss_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_PAUSE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register with its registered companions: clear pulse, lap flag, lap hold
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         clear_out_r  <= 1'b0;
         lap_active_r <= 1'b0;
         lap_reg_r    <= 16'h0000;
      end else begin
         state_r      <= state_nxt_s;
         clear_out_r  <= clear_nxt_s;
         lap_active_r <= (state_nxt_s == ST_LAP);
         if (capture_s) begin
            lap_reg_r <= bus.time_bcd;
         end else begin
            lap_reg_r <= lap_reg_r;
         end
      end
   end

   // Prescaler holds its phase through PAUSE so a partial tick survives stop/start
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         presc_r   <= '0;
         tick_en_r <= 1'b0;
      end else begin
         tick_en_r <= counting_s && (presc_r == PRESC_MAX);
         if (clear_nxt_s || (state_r == ST_IDLE)) begin
            presc_r <= '0;
         end else if (counting_s) begin
            if (presc_r == PRESC_MAX) begin
               presc_r <= '0;
            end else begin
               presc_r <= presc_r + PW'(1);
            end
         end else begin
            presc_r <= presc_r;
         end
      end
   end

   assign bus.tick_en    = tick_en_r;
   assign bus.clear_out  = clear_out_r;
   assign bus.lap_active = lap_active_r;
   assign bus.state      = state_r;
   assign bus.disp_bcd   = lap_active_r ? lap_reg_r : bus.time_bcd;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed + randomized bench for stopwatch_controller against a cycle model
// built from the button-window, event-priority and tick-phase rules.
module tb_stopwatch_controller;
   localparam int CLK_HZ  = 100;
   localparam int TICK_HZ = 10;
   localparam int DEB     = 4;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic clk_in = 1'b0;
   logic rst;

   stopwatch_controller_if sw_if ();

   stopwatch_controller #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk_in(clk_in),
      .rst(rst),
      .bus(sw_if.master)
   );

   always #5 clk_in = ~clk_in;

   int tests = 0;
   int fails = 0;

   // Reference model: state 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
   int          m_state;
   int          m_phase;
   bit          m_tick;
   bit          m_clr;
   bit          m_lapact;
   logic [15:0] m_lap;
   bit          samp [3][DEB+2];
   bit          lvl  [3];
   bit          lvlp [3];

   int          ticks_seen = 0;
   int          clrs_seen  = 0;
   int          trans_seen = 0;
   logic [1:0]  last_state = 2'b00;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_phase = 0; m_tick = 1'b0; m_clr = 1'b0; m_lapact = 1'b0; m_lap = 16'h0000;
      for (int b = 0; b < 3; b++) begin
         lvl[b] = 1'b0; lvlp[b] = 1'b0;
         for (int k = 0; k < DEB + 2; k++) samp[b][k] = 1'b0;
      end
   endtask

   // One clock edge of the reference: samp[b][k] is the raw level k edges ago;
   // the debounced level flips when raw samples 2..DEB+1 edges old all disagree with it.
   task automatic model_edge();
      bit raw [3];
      bit ev  [3];
      bit all_new;
      bit counting;
      bit clr;
      bit cap;
      int nxt;
      raw[0] = sw_if.btn_start_stop;
      raw[1] = sw_if.btn_lap;
      raw[2] = sw_if.btn_clear;
      for (int b = 0; b < 3; b++) begin
         ev[b] = lvl[b] && !lvlp[b];
         for (int k = DEB + 1; k > 0; k--) samp[b][k] = samp[b][k-1];
         samp[b][0] = raw[b];
         all_new = 1'b1;
         for (int k = 2; k <= DEB + 1; k++) if (samp[b][k] == lvl[b]) all_new = 1'b0;
         lvlp[b] = lvl[b];
         if (all_new) lvl[b] = !lvl[b];
      end
      counting = (m_state == 1) || (m_state == 3);
      m_tick   = counting && (m_phase == DIV - 1);
      nxt = m_state; clr = 1'b0; cap = 1'b0;
      if (m_state == 0) begin
         if (ev[2]) clr = 1'b1;
         else if (ev[0]) nxt = 1;
      end else if (m_state == 1) begin
         if (ev[0]) nxt = 2;
         else if (ev[1]) begin cap = 1'b1; nxt = 3; end
      end else if (m_state == 3) begin
         if (ev[2]) nxt = 1;
         else if (ev[0]) nxt = 2;
         else if (ev[1]) cap = 1'b1;
      end else begin
         if (ev[2]) begin clr = 1'b1; nxt = 0; end
         else if (ev[0]) nxt = 1;
      end
      if (clr || m_state == 0) m_phase = 0;
      else if (counting) m_phase = (m_phase + 1) % DIV;
      if (cap) m_lap = sw_if.time_bcd;
      m_clr    = clr;
      m_state  = nxt;
      m_lapact = (nxt == 3);
   endtask

   task automatic step();
      @(posedge clk_in);
      if (rst) model_reset();
      else model_edge();
      @(negedge clk_in);
      chk("state", 16'(sw_if.state), 16'(m_state));
      chk("tick_en", 16'(sw_if.tick_en), 16'(m_tick));
      chk("clear_out", 16'(sw_if.clear_out), 16'(m_clr));
      chk("lap_active", 16'(sw_if.lap_active), 16'(m_lapact));
      chk("disp_bcd", sw_if.disp_bcd, m_lapact ? m_lap : sw_if.time_bcd);
      chk("tick_clear_excl", 16'(sw_if.tick_en & sw_if.clear_out), 16'h0000);
      if (sw_if.tick_en === 1'b1) ticks_seen++;
      if (sw_if.clear_out === 1'b1) clrs_seen++;
      if (sw_if.state !== last_state) trans_seen++;
      last_state = sw_if.state;
   endtask

   task automatic hold(input int n);
      repeat (n) step();
   endtask

   task automatic wait_state(input string tag, input logic [1:0] exp, input int budget, output int n);
      n = 0;
      while (sw_if.state !== exp && n < budget) begin
         step();
         n++;
      end
      chk(tag, 16'(sw_if.state), 16'(exp));
   endtask

   task automatic wait_tick(input string tag, input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (sw_if.tick_en !== 1'b1 && n < budget);
      chk(tag, 16'(sw_if.tick_en), 16'h0001);
   endtask

   task automatic press(input int b, input string tag, input logic [1:0] exp);
      int n;
      if (b == 0) sw_if.btn_start_stop = 1'b1;
      else if (b == 1) sw_if.btn_lap = 1'b1;
      else sw_if.btn_clear = 1'b1;
      wait_state(tag, exp, 20, n);
      hold(2);
      sw_if.btn_start_stop = 1'b0; sw_if.btn_lap = 1'b0; sw_if.btn_clear = 1'b0;
      hold(8);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t0;
      int c0;
      int rcnt [3];
      bit rlvl [3];

      rst = 1'b1;
      sw_if.btn_start_stop = 1'b0; sw_if.btn_lap = 1'b0; sw_if.btn_clear = 1'b0;
      sw_if.time_bcd = 16'h0000;
      model_reset();
      hold(3);
      chk("rst_state", 16'(sw_if.state), 16'h0000);
      chk("rst_lap_active", 16'(sw_if.lap_active), 16'h0000);
      chk("rst_tick", 16'(sw_if.tick_en), 16'h0000);
      rst = 1'b0;
      hold(3);

      // Clean start press: 2 sync + 4 debounce + 1 cycles to RUN, release is silent
      sw_if.btn_start_stop = 1'b1;
      wait_state("start_run", 2'b01, 20, n);
      chk("start_latency", 16'(n), 16'd7);
      hold(13);
      sw_if.btn_start_stop = 1'b0;
      t0 = trans_seen;
      hold(30);
      chk("release_no_event", 16'(trans_seen - t0), 16'h0000);
      wait_tick("tick_a", 20, n);
      wait_tick("tick_b", 20, n);
      chk("tick_period", 16'(n), 16'(DIV));

      // Bouncing start/stop: one transition only, after 4 stable samples
      t0 = trans_seen;
      for (int i = 0; i < 12; i++) begin
         sw_if.btn_start_stop = ((i / 2) % 2 == 0);
         step();
      end
      chk("bounce_no_early_event", 16'(trans_seen - t0), 16'h0000);
      sw_if.btn_start_stop = 1'b1;
      wait_state("bounce_pause", 2'b10, 20, n);
      chk("bounce_latency", 16'(n), 16'd7);
      hold(10);
      sw_if.btn_start_stop = 1'b0;
      hold(10);
      chk("bounce_one_transition", 16'(trans_seen - t0), 16'h0001);
      press(0, "resume_run", 2'b01);

      // Lap capture, recapture and release via clear
      sw_if.time_bcd = 16'h0123;
      sw_if.btn_lap = 1'b1;
      wait_state("lap_enter", 2'b11, 20, n);
      sw_if.time_bcd = 16'h0124;
      hold(3);
      sw_if.time_bcd = 16'h0129;
      sw_if.btn_lap = 1'b0;
      step();
      chk("lap_hold_disp", sw_if.disp_bcd, 16'h0123);
      t0 = ticks_seen;
      hold(20);
      chk("lap_ticks_continue", 16'(ticks_seen - t0), 16'd2);
      sw_if.time_bcd = 16'h0130;
      sw_if.btn_lap = 1'b1;
      hold(9);
      sw_if.btn_lap = 1'b0;
      hold(2);
      sw_if.time_bcd = 16'h0135;
      step();
      chk("lap_recapture", sw_if.disp_bcd, 16'h0130);
      c0 = clrs_seen;
      sw_if.btn_clear = 1'b1;
      wait_state("lap_clear_run", 2'b01, 20, n);
      hold(4);
      sw_if.btn_clear = 1'b0;
      hold(8);
      chk("lap_clear_no_pulse", 16'(clrs_seen - c0), 16'h0000);
      sw_if.time_bcd = 16'h0140;
      step();
      chk("run_disp_live", sw_if.disp_bcd, 16'h0140);

      // Stop with prescaler at 6, resume needs 4 more cycles for the next tick
      wait_tick("pre_stop_tick", 20, n);
      hold(9);
      sw_if.btn_start_stop = 1'b1;
      wait_state("stop_pause", 2'b10, 20, n);
      chk("stop_latency", 16'(n), 16'd7);
      t0 = ticks_seen;
      hold(3);
      sw_if.btn_start_stop = 1'b0;
      hold(15);
      chk("pause_no_tick", 16'(ticks_seen - t0), 16'h0000);
      sw_if.btn_start_stop = 1'b1;
      wait_state("restart_run", 2'b01, 20, n);
      wait_tick("restart_tick", 20, n);
      chk("restart_tick_delay", 16'(n), 16'd4);
      hold(3);
      sw_if.btn_start_stop = 1'b0;
      hold(8);
      press(0, "pause_again", 2'b10);
      c0 = clrs_seen;
      sw_if.btn_clear = 1'b1;
      wait_state("pause_clear_idle", 2'b00, 20, n);
      chk("pause_clear_pulse", 16'(sw_if.clear_out), 16'h0001);
      step();
      chk("clear_one_cycle", 16'(sw_if.clear_out), 16'h0000);
      sw_if.btn_clear = 1'b0;
      hold(8);
      chk("clear_count", 16'(clrs_seen - c0), 16'h0001);

      // Simultaneous clear + start/stop in PAUSE and in RUN
      press(0, "pair_setup_run", 2'b01);
      press(0, "pair_setup_pause", 2'b10);
      sw_if.btn_clear = 1'b1; sw_if.btn_start_stop = 1'b1;
      wait_state("pair_pause_idle", 2'b00, 20, n);
      chk("pair_pause_clear", 16'(sw_if.clear_out), 16'h0001);
      hold(3);
      sw_if.btn_clear = 1'b0; sw_if.btn_start_stop = 1'b0;
      hold(8);
      press(0, "pair_setup_run2", 2'b01);
      sw_if.btn_clear = 1'b1; sw_if.btn_start_stop = 1'b1;
      wait_state("pair_run_pause", 2'b10, 20, n);
      chk("pair_run_noclear", 16'(sw_if.clear_out), 16'h0000);
      hold(3);
      sw_if.btn_clear = 1'b0; sw_if.btn_start_stop = 1'b0;
      hold(8);

      // Asynchronous reset in LAP one cycle before a tick
      press(0, "rst_setup_run", 2'b01);
      press(1, "rst_setup_lap", 2'b11);
      sw_if.time_bcd = 16'h0459;
      wait_tick("rst_pre_tick", 20, n);
      hold(9);
      rst = 1'b1;
      #1;
      chk("rst_async_state", 16'(sw_if.state), 16'h0000);
      chk("rst_async_tick", 16'(sw_if.tick_en), 16'h0000);
      chk("rst_async_lap", 16'(sw_if.lap_active), 16'h0000);
      chk("rst_async_disp", sw_if.disp_bcd, 16'h0459);
      hold(2);
      rst = 1'b0;
      t0 = ticks_seen;
      hold(40);
      chk("no_tick_after_rst", 16'(ticks_seen - t0), 16'h0000);
      chk("idle_after_rst", 16'(sw_if.state), 16'h0000);

      // Random button levels/durations, random live time and occasional reset
      for (int b = 0; b < 3; b++) begin
         rcnt[b] = 0; rlvl[b] = 1'b0;
      end
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (rcnt[b] == 0) begin
               rlvl[b] = 1'($urandom_range(0, 1));
               rcnt[b] = int'($urandom_range(1, 14));
            end else begin
               rcnt[b]--;
            end
         end
         sw_if.btn_start_stop = rlvl[0];
         sw_if.btn_lap        = rlvl[1];
         sw_if.btn_clear      = rlvl[2];
         sw_if.time_bcd       = 16'($urandom());
         rst = ($urandom_range(0, 399) == 0);
         step();
      end
      rst = 1'b0;
      hold(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
